// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_pkg
// Brief    : Shared types and constants for the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_JMP = 2'b01;
    localparam logic [1:0] PCSEL_BR  = 2'b10;

    localparam int SB_EX  = 0;
    localparam int SB_MEM = 1;
    localparam int SB_WB  = 2;

    // Opcodes shared with the instruction decoder
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JMP   = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LOAD  = 6'h23;
    localparam logic [5:0] OP_STORE = 6'h2B;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    typedef struct packed {
        logic       v;
        logic [4:0] dst;
        logic       isLoad;
        logic       isBr;
    } sb_entry_t;

    function automatic logic src_match(sb_entry_t e, logic [4:0] src_a,
                                       logic [4:0] src_b, logic uses_b);
        return e.v && (e.dst != 5'd0) &&
               ((src_a == e.dst) || (uses_b && (src_b == e.dst)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Brief    : Decoder-side inputs and pipeline control outputs of the controller.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if;
    logic       idValid;
    logic [4:0] idSrcA;
    logic [4:0] idSrcB;
    logic       idUsesB;
    logic [4:0] idWriteReg;
    logic       idWbEnable;
    logic       idMemRead;
    logic       idIsBranch;
    logic       idIsJump;
    logic       exBrTaken;
    logic       pcWrite;
    logic       ifidWrite;
    logic       ifidFlush;
    logic       idexBubble;
    logic [1:0] pcSel;

    modport master (
        output idValid, idSrcA, idSrcB, idUsesB, idWriteReg, idWbEnable,
               idMemRead, idIsBranch, idIsJump, exBrTaken,
        input  pcWrite, ifidWrite, ifidFlush, idexBubble, pcSel
    );

    modport slave (
        input  idValid, idSrcA, idSrcB, idUsesB, idWriteReg, idWbEnable,
               idMemRead, idIsBranch, idIsJump, exBrTaken,
        output pcWrite, ifidWrite, ifidFlush, idexBubble, pcSel
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hz_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hz_scoreboard
// Brief    : 3-entry EX/MEM/WB writer scoreboard with per-entry source match.
// Revision : 1.0 - initial release
// ============================================================================
module hz_scoreboard
    import pipe_hazard_ctrl_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_load,
    input  wire logic [4:0] i_wr_reg,
    input  wire logic       i_wb_en,
    input  wire logic       i_mem_read,
    input  wire logic       i_is_branch,
    input  wire logic [4:0] i_src_a,
    input  wire logic [4:0] i_src_b,
    input  wire logic       i_uses_b,
    output logic [2:0]      o_match,
    output logic [2:0]      o_is_load,
    output logic            o_ex_is_br
);

    sb_entry_t [2:0] r_sb;
    sb_entry_t       w_new;

    // isBr is tracked even for non-writers so the branch can be seen in EX
    always_comb begin
        w_new        = '0;
        w_new.v      = i_load && i_wb_en && (i_wr_reg != 5'd0);
        w_new.dst    = i_load ? i_wr_reg : 5'd0;
        w_new.isLoad = i_load && i_mem_read;
        w_new.isBr   = i_load && i_is_branch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb <= '0;
        end else begin
            r_sb <= {r_sb[SB_MEM], r_sb[SB_EX], w_new};
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_match
        assign o_match[gi]   = src_match(r_sb[gi], i_src_a, i_src_b, i_uses_b);
        assign o_is_load[gi] = r_sb[gi].isLoad;
    end

    assign o_ex_is_br = r_sb[SB_EX].isBr;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : ID-stage hazard/redirect sequencer with stall and flush counters.
//            Build option: FORWARD_EN (datapath has full forwarding).
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    pipe_hazard_ctrl_if.slave  hz,
    output logic [CNT_W-1:0]   stallCnt,
    output logic [CNT_W-1:0]   flushCnt
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [2:0] w_match;
    logic [2:0] w_is_load;
    logic       w_ex_is_br;
    logic       w_hazard;
    logic       w_redir_st;
    logic       w_redirect;
    logic       w_stall;
    logic       w_jump;
    logic       w_load;
    logic       w_unused;

    hz_scoreboard u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_wr_reg    (hz.idWriteReg),
        .i_wb_en     (hz.idWbEnable),
        .i_mem_read  (hz.idMemRead),
        .i_is_branch (hz.idIsBranch),
        .i_src_a     (hz.idSrcA),
        .i_src_b     (hz.idSrcB),
        .i_uses_b    (hz.idUsesB),
        .o_match     (w_match),
        .o_is_load   (w_is_load),
        .o_ex_is_br  (w_ex_is_br)
    );

`ifdef FORWARD_EN
    assign w_hazard = w_match[SB_EX] & w_is_load[SB_EX];
`else
    // Write-through register file: a WB match is never a hazard
    assign w_hazard = w_match[SB_EX] | w_match[SB_MEM];
`endif

    assign w_unused = ^{w_match[SB_WB], w_is_load};

    // All controls are gated by rst_n so outputs hold reset values while in reset
    assign w_redir_st = (r_state == REDIRECT);
    assign w_redirect = rst_n & w_ex_is_br & hz.exBrTaken;
    assign w_stall    = rst_n & hz.idValid & w_hazard & ~w_redirect & ~w_redir_st;
    assign w_jump     = rst_n & hz.idValid & hz.idIsJump & ~w_stall
                        & ~w_redirect & ~w_redir_st;
    assign w_load     = hz.idValid & ~w_stall & ~w_redirect & ~w_redir_st;

    always_comb begin
        w_state_nxt = r_state;
        if (w_redirect) begin
            w_state_nxt = REDIRECT;
        end else begin
            case (r_state)
                RUN:      w_state_nxt = w_stall ? STALL : RUN;
                STALL:    w_state_nxt = w_stall ? STALL : RUN;
                REDIRECT: w_state_nxt = RUN;
                default:  w_state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        hz.pcWrite    = 1'b1;
        hz.ifidWrite  = 1'b1;
        hz.ifidFlush  = 1'b0;
        hz.idexBubble = 1'b0;
        hz.pcSel      = PCSEL_SEQ;
        if (w_redirect) begin
            hz.pcSel      = PCSEL_BR;
            hz.ifidFlush  = 1'b1;
            hz.idexBubble = 1'b1;
        end else if (w_stall) begin
            hz.pcWrite    = 1'b0;
            hz.ifidWrite  = 1'b0;
            hz.idexBubble = 1'b1;
        end else if (w_jump) begin
            hz.pcSel      = PCSEL_JMP;
            hz.ifidFlush  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if ((w_redirect || w_jump) && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stallCnt = r_stall_cnt;
    assign flushCnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed self-checking bench for pipe_hazard_ctrl (CNT_W 16 and 4).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [3:0]  stall_cnt4;
    logic [3:0]  flush_cnt4;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_stall = 0;
    int          exp_flush = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus ();
    pipe_hazard_ctrl_if bus4 ();

    assign bus4.idValid    = bus.idValid;
    assign bus4.idSrcA     = bus.idSrcA;
    assign bus4.idSrcB     = bus.idSrcB;
    assign bus4.idUsesB    = bus.idUsesB;
    assign bus4.idWriteReg = bus.idWriteReg;
    assign bus4.idWbEnable = bus.idWbEnable;
    assign bus4.idMemRead  = bus.idMemRead;
    assign bus4.idIsBranch = bus.idIsBranch;
    assign bus4.idIsJump   = bus.idIsJump;
    assign bus4.exBrTaken  = bus.exBrTaken;

    pipe_hazard_ctrl #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hz       (bus.slave),
        .stallCnt (stall_cnt),
        .flushCnt (flush_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .hz       (bus4.slave),
        .stallCnt (stall_cnt4),
        .flushCnt (flush_cnt4)
    );

    task automatic check_eq(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b,
                         input logic ub, input logic [4:0] wr, input logic wb,
                         input logic mr, input logic br, input logic jp);
        bus.idValid    = v;
        bus.idSrcA     = a;
        bus.idSrcB     = b;
        bus.idUsesB    = ub;
        bus.idWriteReg = wr;
        bus.idWbEnable = wb;
        bus.idMemRead  = mr;
        bus.idIsBranch = br;
        bus.idIsJump   = jp;
        bus.exBrTaken  = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, with a jump presented to prove the controls are forced
        rst_n = 1'b0;
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #3;
        check_eq("rst_pcWrite",    32'(bus.pcWrite),    32'd1);
        check_eq("rst_ifidWrite",  32'(bus.ifidWrite),  32'd1);
        check_eq("rst_ifidFlush",  32'(bus.ifidFlush),  32'd0);
        check_eq("rst_idexBubble", 32'(bus.idexBubble), 32'd0);
        check_eq("rst_pcSel",      32'(bus.pcSel),      32'(PCSEL_SEQ));
        check_eq("rst_stallCnt",   32'(stall_cnt),      32'd0);
        check_eq("rst_flushCnt",   32'(flush_cnt),      32'd0);
        check_eq("rst_state",      32'(dut.r_state),    32'(RUN));
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Load-use: LOAD r2 ; ADD r3,r2,r1
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        #2 check_eq("lu_load_pcw", 32'(bus.pcWrite), 32'd1);
        tick();
        drive(1'b1, 5'd2, 5'd1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        check_eq("lu_s1_pcw", 32'(bus.pcWrite),    32'd0);
        check_eq("lu_s1_bub", 32'(bus.idexBubble), 32'd1);
        exp_stall += 1;
        tick();
        if (FWD) idle();
        #2 check_eq("lu_s2_pcw", 32'(bus.pcWrite), FWD ? 32'd1 : 32'd0);
        exp_stall += FWD ? 0 : 1;
        tick();
        if (FWD) idle();
        #2;
        check_eq("lu_go_pcw", 32'(bus.pcWrite),    32'd1);
        check_eq("lu_go_bub", 32'(bus.idexBubble), 32'd0);
        tick();
        check_eq("lu_stallCnt", 32'(stall_cnt), 32'(exp_stall));
        idle();
        repeat (3) tick();

        // ALU-use: ADD r2,r1,r1 ; ADD r3,r2,r1
        drive(1'b1, 5'd1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd2, 5'd1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 check_eq("au_s1_pcw", 32'(bus.pcWrite), FWD ? 32'd1 : 32'd0);
        exp_stall += FWD ? 0 : 1;
        tick();
        if (FWD) idle();
        #2 check_eq("au_s2_pcw", 32'(bus.pcWrite), FWD ? 32'd1 : 32'd0);
        exp_stall += FWD ? 0 : 1;
        tick();
        if (FWD) idle();
        #2 check_eq("au_wb_pcw", 32'(bus.pcWrite), 32'd1);
        tick();
        check_eq("au_stallCnt", 32'(stall_cnt), 32'(exp_stall));
        idle();
        repeat (3) tick();

        // Destination r0: ADDI r0,r0,5 ; ADD r1,r0,r0
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        check_eq("r0_pcw", 32'(bus.pcWrite),    32'd1);
        check_eq("r0_bub", 32'(bus.idexBubble), 32'd0);
        tick();
        idle();
        repeat (3) tick();
        check_eq("r0_stallCnt", 32'(stall_cnt), 32'(exp_stall));

        // Taken BEQ in EX while a dependent SUB r7,r6,r1 would stall in ID
        drive(1'b1, 5'd1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd4, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2 check_eq("br_beq_pcw", 32'(bus.pcWrite), 32'd1);
        tick();
        drive(1'b1, 5'd6, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 check_eq("br_hz_pcw", 32'(bus.pcWrite), FWD ? 32'd1 : 32'd0);
        bus.exBrTaken = 1'b1;
        #1;
        check_eq("br_pcSel", 32'(bus.pcSel),      32'(PCSEL_BR));
        check_eq("br_flush", 32'(bus.ifidFlush),  32'd1);
        check_eq("br_bub",   32'(bus.idexBubble), 32'd1);
        check_eq("br_pcw",   32'(bus.pcWrite),    32'd1);
        check_eq("br_ifw",   32'(bus.ifidWrite),  32'd1);
        exp_flush += 1;
        tick();
        check_eq("br_st_redir", 32'(dut.r_state), 32'(REDIRECT));
        check_eq("br_stallCnt", 32'(stall_cnt),   32'(exp_stall));
        check_eq("br_flushCnt", 32'(flush_cnt),   32'(exp_flush));
        idle();
        #2;
        check_eq("br_rd_pcSel", 32'(bus.pcSel),     32'(PCSEL_SEQ));
        check_eq("br_rd_flush", 32'(bus.ifidFlush), 32'd0);
        tick();
        check_eq("br_st_run", 32'(dut.r_state), 32'(RUN));
        drive(1'b1, 5'd7, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 check_eq("br_squashed_pcw", 32'(bus.pcWrite), 32'd1);
        tick();
        idle();
        repeat (3) tick();

        // Jump in ID
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        check_eq("jmp_pcSel", 32'(bus.pcSel),      32'(PCSEL_JMP));
        check_eq("jmp_flush", 32'(bus.ifidFlush),  32'd1);
        check_eq("jmp_bub",   32'(bus.idexBubble), 32'd0);
        check_eq("jmp_pcw",   32'(bus.pcWrite),    32'd1);
        exp_flush += 1;
        tick();
        idle();
        #2;
        check_eq("jmp_nx_pcSel", 32'(bus.pcSel),     32'(PCSEL_SEQ));
        check_eq("jmp_nx_flush", 32'(bus.ifidFlush), 32'd0);
        check_eq("jmp_flushCnt", 32'(flush_cnt),     32'(exp_flush));
        tick();
        repeat (3) tick();

        // Reset asserted in the middle of a load-use stall
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd2, 5'd1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 check_eq("rs_pre_pcw", 32'(bus.pcWrite), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("rs_pcw",      32'(bus.pcWrite),    32'd1);
        check_eq("rs_ifw",      32'(bus.ifidWrite),  32'd1);
        check_eq("rs_bub",      32'(bus.idexBubble), 32'd0);
        check_eq("rs_pcSel",    32'(bus.pcSel),      32'(PCSEL_SEQ));
        check_eq("rs_stallCnt", 32'(stall_cnt),      32'd0);
        check_eq("rs_flushCnt", 32'(flush_cnt),      32'd0);
        check_eq("rs_state",    32'(dut.r_state),    32'(RUN));
        exp_stall = 0;
        exp_flush = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #2 check_eq("rs_rel_pcw", 32'(bus.pcWrite), 32'd1);
        tick();
        idle();
        repeat (3) tick();

        // Saturation: 20 load-use pairs; the 4-bit counter must hold at 15
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            drive(1'b1, 5'd2, 5'd1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
            repeat (FWD ? 2 : 3) tick();
            exp_stall += FWD ? 1 : 2;
        end
        idle();
        tick();
        check_eq("sat_stallCnt16", 32'(stall_cnt),  32'(exp_stall));
        check_eq("sat_stallCnt4",  32'(stall_cnt4), 32'd15);
        check_eq("sat_flushCnt4",  32'(flush_cnt4), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage (IF/ID/EX/MEM/WB) processor. It sits beside the ID stage and consumes the instruction decoder's outputs. It tracks in-flight register writers in a 3-entry scoreboard and generates PC/IF-ID hold, ID-EX bubble, IF-ID flush and PC-select controls for RAW hazards, jumps and taken branches. It also keeps stall and flush performance counters.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters (saturating).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset, asynchronous, active-low.
- idValid  in  1  ID holds a real instruction.
- idSrcA  in  5  rs field, instruction[25:21].
- idSrcB  in  5  rt field, instruction[20:16].
- idUsesB  in  1  rt is a source (R-type, STORE, BEQ).
- idWriteReg  in  5  decoder writeReg.
- idWbEnable  in  1  decoder wbEnable.
- idMemRead  in  1  decoder memRead.
- idIsBranch  in  1  decoder isBranch.
- idIsJump  in  1  decoder isJump.
- exBrTaken  in  1  BEQ condition true, valid in the cycle the branch is in EX.
- pcWrite  out  1  0 holds the PC.
- ifidWrite  out  1  0 holds the IF/ID register.
- ifidFlush  out  1  1 loads a NOP into IF/ID.
- idexBubble  out  1  1 loads a NOP into ID/EX.
- pcSel  out  2  00 sequential (PC+4), 01 jump target, 10 branch target.
- stallCnt  out  CNT_W  cycles with a hazard stall.
- flushCnt  out  CNT_W  redirect events (jumps plus taken branches).

## Operation
- Scoreboard entries EX, MEM and WB each hold {v, dst, isLoad, isBr}. Every clock, WB is dropped, MEM moves to WB and EX moves to MEM.
- EX loads the ID fields when idValid=1, the cycle does not stall and the cycle does not flush ID. Otherwise EX loads v=0. Entry v is set only when wbEnable=1 and dst!=0.
- Match: idSrcA==entry.dst, or idUsesB=1 and idSrcB==entry.dst, with entry.v=1. Register 0 never matches.
- The hazard rule depends on FORWARD_EN (see Configuration).
- Stall (hazard=1 and idValid=1): pcWrite=0, ifidWrite=0, idexBubble=1, stallCnt increments.
- Taken branch (EX.isBr=1 and exBrTaken=1): pcSel=10, ifidFlush=1, idexBubble=1, flushCnt increments. This overrides any stall and any ID jump, because ID is wrong-path.
- Jump in ID, no stall and no taken branch: pcSel=01, ifidFlush=1, flushCnt increments. The jump itself proceeds into EX as a non-writer.
- FSM states:
  - RUN to STALL when a hazard stall asserts.
  - STALL to RUN when the hazard clears.
  - Any state to REDIRECT on a taken branch.
  - REDIRECT to RUN unconditionally after 1 cycle.
- In REDIRECT the ID contents are a flushed NOP, so hazard and jump detection are masked.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset (async assert, sync release): scoreboard v=0, FSM=RUN, counters 0. Outputs during reset: pcWrite=1, ifidWrite=1, ifidFlush=0, idexBubble=0, pcSel=00.
- All controls are combinational from the current inputs and registered state, usable in the same cycle. Scoreboard, FSM and counters update on posedge clk.
- Load-use with forwarding: exactly 1 stall cycle.
- Without forwarding: up to 2 stall cycles. The register file is write-through, so a WB match never stalls.
- Taken branch: 2 wrong-path slots are squashed (IF/ID and ID/EX). Jump: 1 slot is squashed (IF/ID).
- A taken branch during STALL flushes the stalled instruction. The scoreboard EX entry becomes v=0 and stallCnt does not increment that cycle.
- Reset mid-stall: the scoreboard is cleared immediately and no stale hazard survives reset release.

## Configuration
- FORWARD_EN defined: the datapath has EX/MEM/WB forwarding. Hazard = match on an EX entry with isLoad=1 only.
- FORWARD_EN undefined: no forwarding. Hazard = match on the EX or MEM entry, regardless of isLoad.

## Structure
- Shared package holds:
  - the pcSel encodings PCSEL_SEQ, PCSEL_JMP and PCSEL_BR;
  - the FSM state enum {RUN, STALL, REDIRECT};
  - the scoreboard entry struct;
  - the opcode constants shared with the decoder.
- One natural sub-module, hz_scoreboard: the 3-entry shift register plus match logic, outputting the per-entry match and isLoad flags.

## Test plan
- Load-use: LOAD r2 followed by ADD r3,r2,r1, with FORWARD_EN -> exactly 1 cycle of pcWrite=0 and idexBubble=1; stallCnt=1.
- Same sequence without FORWARD_EN -> 2 stall cycles; stallCnt=2. ADD r3,r2,r1 after ADD r2 -> 2 stalls without forwarding, 0 with.
- Destination r0: ADDI r0,r0,5 then ADD r1,r0,r0 -> no stall in either build.
- Taken BEQ with a stalled dependent in ID:
  - stimulus: exBrTaken=1 during STALL;
  - required: pcSel=10, ifidFlush=1, idexBubble=1, stall dropped, state REDIRECT then RUN; flushCnt=1.
- Jump: JMP in ID -> pcSel=01 and ifidFlush=1 for 1 cycle; the next sequential instruction never enters EX.
- Reset and saturation:
  - assert rst_n=0 mid-stall -> all outputs take their reset values immediately;
  - with CNT_W=4, 20 stall cycles -> stallCnt holds at 15.
